// File: rtl/led_pkg.sv
// Shared types and register map for the LED pattern driver.
// Imported by the top and its bench; no logic lives here beyond a small helper.
package led_pkg;

  typedef enum logic [1:0] {
    ModeFollow  = 2'd0,
    ModeBlink   = 2'd1,
    ModePwm     = 2'd2,
    ModeBreathe = 2'd3
  } mode_e;

  typedef enum logic [2:0] {
    StFollow,
    StBlinkOn,
    StBlinkOff,
    StPwm,
    StBrUp,
    StBrDown
  } state_e;

  localparam int unsigned CTRL_OFS       = 0;
  localparam int unsigned PRESCALE_OFS   = 1;
  localparam int unsigned BLINK_HALF_OFS = 2;
  localparam int unsigned DUTY_OFS       = 3;
  localparam int unsigned STATUS_OFS     = 4;
  localparam int unsigned NUM_REGS       = 5;

  localparam int unsigned CTRL_MODE_LSB   = 0;
  localparam int unsigned CTRL_MODE_MSB   = 1;
  localparam int unsigned CTRL_INVERT_BIT = 2;

  // State the FSM restarts in whenever the pattern is held.
  function automatic state_e entry_state(mode_e mode);
    state_e st;
    st = StFollow;
    case (mode)
      ModeFollow:  st = StFollow;
      ModeBlink:   st = StBlinkOn;
      ModePwm:     st = StPwm;
      ModeBreathe: st = StBrUp;
      default:     st = StFollow;
    endcase
    return st;
  endfunction

endpackage

// File: rtl/led_pattern_driver_if.sv
// CPU register bus seen by the LED pattern driver: address, write data,
// combinational read data and the read/write strobe.
interface led_pattern_driver_if #(
  parameter int unsigned AddrWidth = 15,
  parameter int unsigned DataWidth = 16
);
  logic [AddrWidth-1:0] address_i;
  logic [DataWidth-1:0] data_i;
  logic [DataWidth-1:0] data_o;
  logic                 rd_wr_i;

  modport master (output address_i, output data_i, output rd_wr_i, input data_o);
  modport slave  (input address_i, input data_i, input rd_wr_i, output data_o);
endinterface

// File: rtl/led_tick_prescaler.sv
// Tick generator: counts 0..prescale_i and pulses tick_o on the terminal count.
// clear_i restarts the count from zero.
module led_tick_prescaler (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        clear_i,
  input  logic [15:0] prescale_i,
  output logic        tick_o
);

  logic [15:0] cnt_q, cnt_d;

  assign tick_o = (cnt_q == prescale_i);

  always_comb begin
    cnt_d = cnt_q + 16'd1;
    if (clear_i || tick_o) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/led_pattern_driver.sv
// Turns the LED request bit into a follow/blink/PWM/breathe pattern on the pin.
// Configured through a five-register window on the CPU bus.
module led_pattern_driver
  import led_pkg::*;
#(
  parameter int unsigned BaseAddress   = 0,
  parameter int unsigned address_width = 15,
  parameter int unsigned data_width    = 16,
  parameter int unsigned PWM_BITS      = 8
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  led_pattern_driver_if.slave   bus,
  input  logic                  led_req_i,
  output logic                  led_o
);

  localparam logic [PWM_BITS-1:0] PwmMax = '1;

  // Address decode done one bit wider so addresses below the base borrow out.
  logic [address_width:0] ofs_w;
  logic                   hit;
  logic [2:0]             sel;
  logic                   wr_en, wr_ctrl, wr_prescale, wr_blink_half, wr_duty;
  mode_e                  wr_mode;

  assign ofs_w = {1'b0, bus.address_i} - (address_width + 1)'(BaseAddress);
  assign hit   = !ofs_w[address_width] && (ofs_w < (address_width + 1)'(NUM_REGS));
  assign sel   = ofs_w[2:0];
  assign wr_en = bus.rd_wr_i && hit;

  assign wr_ctrl       = wr_en && (sel == 3'(CTRL_OFS));
  assign wr_prescale   = wr_en && (sel == 3'(PRESCALE_OFS));
  assign wr_blink_half = wr_en && (sel == 3'(BLINK_HALF_OFS));
  assign wr_duty       = wr_en && (sel == 3'(DUTY_OFS));
  assign wr_mode       = mode_e'(bus.data_i[CTRL_MODE_MSB:CTRL_MODE_LSB]);

  mode_e               mode_q, mode_d;
  logic                invert_q, invert_d;
  logic [15:0]         prescale_q, prescale_d;
  logic [15:0]         blink_half_q, blink_half_d;
  logic [PWM_BITS-1:0] duty_q, duty_d;

  always_comb begin
    mode_d       = mode_q;
    invert_d     = invert_q;
    prescale_d   = prescale_q;
    blink_half_d = blink_half_q;
    duty_d       = duty_q;
    if (wr_ctrl) begin
      mode_d   = wr_mode;
      invert_d = bus.data_i[CTRL_INVERT_BIT];
    end
    if (wr_prescale)   prescale_d   = bus.data_i[15:0];
    if (wr_blink_half) blink_half_d = bus.data_i[15:0];
    if (wr_duty)       duty_d       = bus.data_i[PWM_BITS-1:0];
  end

  // Pattern restarts from its entry state whenever the request drops or the mode changes.
  logic hold;
  logic tick;

  assign hold = !led_req_i || (wr_ctrl && (wr_mode != mode_q));

  led_tick_prescaler u_prescaler (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .clear_i    (hold || wr_prescale),
    .prescale_i (prescale_q),
    .tick_o     (tick)
  );

  state_e              state_q, state_d;
  logic [15:0]         blink_cnt_q, blink_cnt_d;
  logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
  logic [PWM_BITS-1:0] level_q, level_d;

  always_comb begin
    state_d     = state_q;
    blink_cnt_d = blink_cnt_q;
    pwm_cnt_d   = pwm_cnt_q;
    level_d     = level_q;
    if (hold) begin
      state_d     = entry_state(wr_ctrl ? wr_mode : mode_q);
      blink_cnt_d = '0;
      pwm_cnt_d   = '0;
      level_d     = '0;
    end else if (tick) begin
      unique case (state_q)
        StBlinkOn, StBlinkOff: begin
          if (blink_cnt_q == blink_half_q) begin
            blink_cnt_d = '0;
            state_d     = (state_q == StBlinkOn) ? StBlinkOff : StBlinkOn;
          end else begin
            blink_cnt_d = blink_cnt_q + 16'd1;
          end
        end
        StPwm: pwm_cnt_d = pwm_cnt_q + 1'b1;
        StBrUp: begin
          pwm_cnt_d = pwm_cnt_q + 1'b1;
          if (pwm_cnt_q == PwmMax) begin
            if (level_q == PwmMax) state_d = StBrDown;
            else                   level_d = level_q + 1'b1;
          end
        end
        StBrDown: begin
          pwm_cnt_d = pwm_cnt_q + 1'b1;
          if (pwm_cnt_q == PwmMax) begin
            if (level_q == '0) state_d = StBrUp;
            else               level_d = level_q - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  logic pattern;
  logic led_d, led_q;

  always_comb begin
    pattern = 1'b0;
    unique case (mode_q)
      ModeFollow:  pattern = 1'b1;
      ModeBlink:   pattern = (state_q == StBlinkOn);
      ModePwm:     pattern = (pwm_cnt_q < duty_q);
      ModeBreathe: pattern = (pwm_cnt_q < level_q);
      default:     pattern = 1'b0;
    endcase
    led_d = (pattern & led_req_i) ^ invert_q;
  end

  assign led_o = led_q;

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      mode_q       <= ModeFollow;
      invert_q     <= 1'b0;
      prescale_q   <= '0;
      blink_half_q <= '0;
      duty_q       <= '0;
      state_q      <= StFollow;
      blink_cnt_q  <= '0;
      pwm_cnt_q    <= '0;
      level_q      <= '0;
      led_q        <= 1'b0;
    end else begin
      mode_q       <= mode_d;
      invert_q     <= invert_d;
      prescale_q   <= prescale_d;
      blink_half_q <= blink_half_d;
      duty_q       <= duty_d;
      state_q      <= state_d;
      blink_cnt_q  <= blink_cnt_d;
      pwm_cnt_q    <= pwm_cnt_d;
      level_q      <= level_d;
      led_q        <= led_d;
    end
  end

  always_comb begin
    bus.data_o = '0;
    if (hit && !bus.rd_wr_i) begin
      case (sel)
        3'(CTRL_OFS):       bus.data_o = data_width'({invert_q, mode_q});
        3'(PRESCALE_OFS):   bus.data_o = data_width'(prescale_q);
        3'(BLINK_HALF_OFS): bus.data_o = data_width'(blink_half_q);
        3'(DUTY_OFS):       bus.data_o = data_width'(duty_q);
        3'(STATUS_OFS):     bus.data_o = data_width'({state_q == StBrDown,
                                                      state_q == StBlinkOn, led_q});
        default:            bus.data_o = '0;
      endcase
    end
  end

endmodule
